// File: rtl/nco_ctrl.sv
// nco_ctrl: command sequencer owning the NCO enable, tuning word and waveform-RAM load port.
// Optional trailing checksum byte on each load is enabled with `define NCO_CTRL_CHECKSUM_EN.
module nco_ctrl #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 4096,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [15:0]           cmd_data_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic [7:0]            byte_data_i,
  output logic                  nco_en_o,
  output logic [10:0]           tunning_word_o,
  output logic [7:0]            wave_data_o,
  output logic [ADDR_WIDTH-1:0] wave_addr_o,
  output logic                  wave_load_en_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  err_o
);

  localparam logic [1:0] OP_SET_TW  = 2'd0;
  localparam logic [1:0] OP_ENABLE  = 2'd1;
  localparam logic [1:0] OP_DISABLE = 2'd2;
  localparam logic [1:0] OP_LOAD    = 2'd3;

  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [15:0]         IDLE_LAST = 16'(TIMEOUT_CYC - 1);

`ifdef NCO_CTRL_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_LOAD, S_CKSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_LOAD, S_DONE} state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic                  r_cmd_ready;
  logic                  r_byte_ready;
  logic                  r_en;
  logic                  r_prev_en;
  logic [10:0]           r_tw;
  logic [7:0]            r_wdata;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_wen;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [15:0]           r_idle;

  logic                  w_cmd_hs;
  logic                  w_byte_hs;
  logic                  w_in_load;
  logic                  w_idle_expired;
  logic                  w_last_byte;
  logic                  w_err_set;
  logic [ADDR_WIDTH:0]   w_len;
  logic [ADDR_WIDTH:0]   w_n;
  logic [ADDR_WIDTH-1:0] w_last;
  logic                  w_unused;

  assign w_cmd_hs  = cmd_valid_i & r_cmd_ready;
  assign w_byte_hs = byte_valid_i & r_byte_ready;

`ifdef NCO_CTRL_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_cksum_bad;
  assign w_cksum_bad = (r_sum + byte_data_i) != 8'h00;
  assign w_in_load   = (r_state == S_LOAD) || (r_state == S_CKSUM);
`else
  assign w_in_load   = (r_state == S_LOAD);
`endif

  // Only the low bits of cmd_data_i carry meaning for any opcode.
  assign w_unused = ^cmd_data_i;

  assign w_len  = {1'b0, cmd_data_i[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(1);
  assign w_n    = (w_len > DEPTH_W) ? DEPTH_W : w_len;
  assign w_last = w_n[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  assign w_idle_expired = w_in_load & ~w_byte_hs & (r_idle == IDLE_LAST);
  assign w_last_byte    = (r_state == S_LOAD) & w_byte_hs & (r_addr == r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs && (cmd_op_i == OP_LOAD)) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_last_byte) begin
`ifdef NCO_CTRL_CHECKSUM_EN
          w_next = S_CKSUM;
`else
          w_next = S_DONE;
`endif
        end else if (w_idle_expired) begin
          w_next    = S_DONE;
          w_err_set = 1'b1;
        end
      end
`ifdef NCO_CTRL_CHECKSUM_EN
      S_CKSUM: begin
        if (w_byte_hs) begin
          w_next    = S_DONE;
          w_err_set = w_cksum_bad;
        end else if (w_idle_expired) begin
          w_next    = S_DONE;
          w_err_set = 1'b1;
        end
      end
`endif
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Handshake-facing outputs are registered from the next state so they always match it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_ready  <= 1'b0;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cmd_ready  <= (w_next == S_IDLE);
`ifdef NCO_CTRL_CHECKSUM_EN
      r_byte_ready <= (w_next == S_LOAD) || (w_next == S_CKSUM);
`else
      r_byte_ready <= (w_next == S_LOAD);
`endif
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_prev_en <= 1'b0;
      r_tw      <= '0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_last    <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_cmd_hs) begin
        case (cmd_op_i)
          OP_SET_TW:  r_tw <= cmd_data_i[10:0];
          OP_ENABLE:  r_en <= 1'b1;
          OP_DISABLE: r_en <= 1'b0;
          default: begin
            r_prev_en <= r_en;
            r_en      <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_last    <= w_last;
          end
        endcase
      end
      if ((r_state == S_LOAD) && w_byte_hs) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_next == S_DONE) begin
        r_en <= r_prev_en;
      end
    end
  end

  // RAM write port: one-cycle strobe after each data-byte handshake; addr/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_idle  <= '0;
    end else begin
      r_wen <= 1'b0;
      if ((r_state == S_LOAD) && w_byte_hs) begin
        r_wen   <= 1'b1;
        r_waddr <= r_addr;
        r_wdata <= byte_data_i;
      end
      if (!w_in_load || w_byte_hs) begin
        r_idle <= '0;
      end else begin
        r_idle <= r_idle + 16'd1;
      end
    end
  end

`ifdef NCO_CTRL_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if ((r_state == S_IDLE) && w_cmd_hs && (cmd_op_i == OP_LOAD)) begin
      r_sum <= '0;
    end else if ((r_state == S_LOAD) && w_byte_hs) begin
      r_sum <= r_sum + byte_data_i;
    end
  end
`endif

  assign cmd_ready_o    = r_cmd_ready;
  assign byte_ready_o   = r_byte_ready;
  assign nco_en_o       = r_en;
  assign tunning_word_o = r_tw;
  assign wave_data_o    = r_wdata;
  assign wave_addr_o    = r_waddr;
  assign wave_load_en_o = r_wen;
  assign busy_o         = r_busy;
  assign load_done_o    = r_done;
  assign err_o          = r_err;

endmodule

// File: tb/tb_nco_ctrl.sv
// Directed self-checking bench for nco_ctrl (short timeout so the abort path runs quickly).
module tb_nco_ctrl;
  localparam int AW = 12;
  localparam int DEPTH = 4096;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i = 2'd0;
  logic [15:0]   cmd_data_i = 16'd0;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic [7:0]    byte_data_i = 8'd0;
  logic          nco_en_o;
  logic [10:0]   tunning_word_o;
  logic [7:0]    wave_data_o;
  logic [AW-1:0] wave_addr_o;
  logic          wave_load_en_o;
  logic          busy_o;
  logic          load_done_o;
  logic          err_o;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int en_in_load = 0;
  logic [7:0] run_sum = 8'd0;
  logic [AW-1:0] wr_addr[$];
  logic [7:0]    wr_data[$];
  int            wr_cyc[$];

  nco_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i), .cmd_data_i(cmd_data_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .byte_data_i(byte_data_i),
    .nco_en_o(nco_en_o), .tunning_word_o(tunning_word_o), .wave_data_o(wave_data_o),
    .wave_addr_o(wave_addr_o), .wave_load_en_o(wave_load_en_o), .busy_o(busy_o),
    .load_done_o(load_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wave_load_en_o === 1'b1) begin
      wr_addr.push_back(wave_addr_o);
      wr_data.push_back(wave_data_o);
      wr_cyc.push_back(cyc);
    end
    if (load_done_o === 1'b1) done_cnt++;
    if (busy_o === 1'b1 && load_done_o !== 1'b1 && nco_en_o === 1'b1) en_in_load++;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    en_in_load = 0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    while (cmd_ready_o !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    vecs++;
    if (t >= 100) begin errs++; $display("FAIL cmd_ready_wait: cmd_ready_o=%b required 1", cmd_ready_o); end
    if (op == 2'd3) run_sum = 8'd0;
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_data_i = d;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    byte_valid_i = 1'b1; byte_data_i = b;
    while (byte_ready_o !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    vecs++;
    if (t >= 200) begin errs++; $display("FAIL byte_ready_wait: byte_ready_o=%b required 1", byte_ready_o); end
    run_sum = run_sum + b;
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic finish_cksum(input logic good);
`ifdef NCO_CTRL_CHECKSUM_EN
    put_byte(good ? (8'h00 - run_sum) : (8'h01 - run_sum));
`else
    if (good !== 1'b1) $display("note: bad checksum requested without checksum build");
`endif
  endtask

  task automatic wait_done();
    int t = 0;
    while (load_done_o !== 1'b1 && t < 500) begin @(negedge clk); t++; end
    vecs++;
    if (t >= 500) begin errs++; $display("FAIL load_done_wait: load_done_o=%b required 1", load_done_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    vecs++;
    if ({cmd_ready_o, byte_ready_o, nco_en_o, tunning_word_o, wave_data_o, wave_addr_o,
         wave_load_en_o, busy_o, load_done_o, err_o} !== '0) begin
      errs++; $display("FAIL reset_outputs: en=%b tw=%h busy=%b rdy=%b err=%b required all 0",
                       nco_en_o, tunning_word_o, busy_o, cmd_ready_o, err_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vecs++; if (cmd_ready_o !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready: %b required 1", cmd_ready_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy: %b required 0", busy_o); end
  endtask

  task automatic test_set_tw_enable();
    clear_log();
    send_cmd(2'd0, 16'h0123);
    vecs++; if (tunning_word_o !== 11'h123) begin errs++; $display("FAIL set_tw: %h required 123", tunning_word_o); end
    send_cmd(2'd1, 16'h0000);
    vecs++; if (nco_en_o !== 1'b1) begin errs++; $display("FAIL enable: %b required 1", nco_en_o); end
    vecs++; if (busy_o !== 1'b0) begin errs++; $display("FAIL enable_busy: %b required 0", busy_o); end
    send_cmd(2'd0, 16'hA5C3);
    vecs++; if (tunning_word_o !== 11'h5C3) begin errs++; $display("FAIL set_tw_upper_ignored: %h required 5c3", tunning_word_o); end
    send_cmd(2'd2, 16'h0000);
    vecs++; if (nco_en_o !== 1'b0) begin errs++; $display("FAIL disable: %b required 0", nco_en_o); end
    vecs++; if (wr_addr.size() != 0) begin errs++; $display("FAIL no_writes: %0d writes required 0", wr_addr.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    send_cmd(2'd1, 16'h0000);
    clear_log();
    send_cmd(2'd3, 16'h0003);
    vecs++; if (nco_en_o !== 1'b0) begin errs++; $display("FAIL b2b_en_off: %b required 0", nco_en_o); end
    vecs++; if (busy_o !== 1'b1) begin errs++; $display("FAIL b2b_busy: %b required 1", busy_o); end
    vecs++; if (cmd_ready_o !== 1'b0) begin errs++; $display("FAIL b2b_cmd_ready: %b required 0", cmd_ready_o); end
    put_byte(8'h10); put_byte(8'h20); put_byte(8'h30); put_byte(8'h40);
    finish_cksum(1'b1);
    wait_done();
    vecs++; if (wr_addr.size() != 4) begin errs++; $display("FAIL b2b_count: %0d required 4", wr_addr.size()); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      exp = 8'((i + 1) * 16);
      vecs++; if (wr_addr[i] !== AW'(i)) begin errs++; $display("FAIL b2b_addr%0d: %h required %h", i, wr_addr[i], i); end
      vecs++; if (wr_data[i] !== exp) begin errs++; $display("FAIL b2b_data%0d: %h required %h", i, wr_data[i], exp); end
    end
    if (wr_cyc.size() == 4) begin
      vecs++; if (wr_cyc[3] - wr_cyc[0] != 3) begin errs++; $display("FAIL b2b_spacing: %0d cycles required 3", wr_cyc[3] - wr_cyc[0]); end
    end
    vecs++; if (nco_en_o !== 1'b1) begin errs++; $display("FAIL b2b_en_restored: %b required 1", nco_en_o); end
    vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL b2b_err: %b required 0", err_o); end
    vecs++; if (done_cnt != 1) begin errs++; $display("FAIL b2b_done_pulses: %0d required 1", done_cnt); end
    vecs++; if (en_in_load != 0) begin errs++; $display("FAIL b2b_en_during_load: %0d cycles required 0", en_in_load); end
    vecs++; if (tunning_word_o !== 11'h5C3) begin errs++; $display("FAIL b2b_tw_kept: %h required 5c3", tunning_word_o); end
    vecs++; if (cmd_ready_o !== 1'b1) begin errs++; $display("FAIL b2b_idle_ready: %b required 1", cmd_ready_o); end
  endtask

  task automatic test_clamp();
    int bad_addr = 0;
    int bad_data = 0;
    send_cmd(2'd2, 16'h0000);
    clear_log();
    send_cmd(2'd3, 16'hFFFF);
    for (int i = 0; i < DEPTH; i++) put_byte(8'(i * 7 + 3));
    finish_cksum(1'b1);
    wait_done();
    vecs++; if (wr_addr.size() != DEPTH) begin errs++; $display("FAIL clamp_count: %0d required %0d", wr_addr.size(), DEPTH); end
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== AW'(i)) bad_addr++;
      if (wr_data[i] !== 8'(i * 7 + 3)) bad_data++;
    end
    vecs++; if (bad_addr != 0) begin errs++; $display("FAIL clamp_addr: %0d wrong required 0", bad_addr); end
    vecs++; if (bad_data != 0) begin errs++; $display("FAIL clamp_data: %0d wrong required 0", bad_data); end
    vecs++; if (nco_en_o !== 1'b0) begin errs++; $display("FAIL clamp_en: %b required 0", nco_en_o); end
    @(negedge clk); byte_valid_i = 1'b1; byte_data_i = 8'hEE;
    repeat (5) @(negedge clk);
    vecs++; if (byte_ready_o !== 1'b0) begin errs++; $display("FAIL idle_byte_ready: %b required 0", byte_ready_o); end
    vecs++; if (wr_addr.size() != DEPTH) begin errs++; $display("FAIL idle_byte_write: %0d writes required %0d", wr_addr.size(), DEPTH); end
    byte_valid_i = 1'b0;
  endtask

  task automatic test_timeout();
    int cnt = 0;
    send_cmd(2'd1, 16'h0000);
    clear_log();
    send_cmd(2'd3, 16'h0007);
    put_byte(8'h55); put_byte(8'h66);
    while (load_done_o !== 1'b1 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
    vecs++; if (cnt != TO) begin errs++; $display("FAIL timeout_cycles: %0d required %0d", cnt, TO); end
    vecs++; if (err_o !== 1'b1) begin errs++; $display("FAIL timeout_err: %b required 1", err_o); end
    @(posedge clk); #1;
    vecs++; if (wr_addr.size() != 2) begin errs++; $display("FAIL timeout_writes: %0d required 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      vecs++; if (wr_addr[1] !== AW'(1) || wr_data[1] !== 8'h66) begin
        errs++; $display("FAIL timeout_last_write: addr %h data %h required 001/66", wr_addr[1], wr_data[1]);
      end
    end
    vecs++; if (nco_en_o !== 1'b1) begin errs++; $display("FAIL timeout_en_restored: %b required 1", nco_en_o); end
    vecs++; if (done_cnt != 1) begin errs++; $display("FAIL timeout_done_pulses: %0d required 1", done_cnt); end
    send_cmd(2'd3, 16'h0000);
    vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL err_cleared: %b required 0", err_o); end
    put_byte(8'h77);
    finish_cksum(1'b1);
    wait_done();
    vecs++; if (err_o !== 1'b0 || nco_en_o !== 1'b1) begin errs++; $display("FAIL reload: err %b en %b required 0/1", err_o, nco_en_o); end
  endtask

  task automatic test_reset_midload();
    clear_log();
    send_cmd(2'd3, 16'h000F);
    for (int i = 0; i < 5; i++) put_byte(8'(8'hA0 + i));
    @(negedge clk); #2 rst_n = 1'b0; #1;
    vecs++;
    if ({cmd_ready_o, byte_ready_o, nco_en_o, tunning_word_o, wave_data_o, wave_addr_o,
         wave_load_en_o, busy_o, load_done_o, err_o} !== '0) begin
      errs++; $display("FAIL midload_reset: en=%b busy=%b brdy=%b addr=%h required all 0",
                       nco_en_o, busy_o, byte_ready_o, wave_addr_o);
    end
    vecs++; if (wr_addr.size() != 5) begin errs++; $display("FAIL midload_writes: %0d required 5", wr_addr.size()); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vecs++; if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || nco_en_o !== 1'b0) begin
      errs++; $display("FAIL midload_release: rdy %b busy %b en %b required 1/0/0", cmd_ready_o, busy_o, nco_en_o);
    end
    send_cmd(2'd0, 16'h0321);
    vecs++; if (tunning_word_o !== 11'h321) begin errs++; $display("FAIL post_reset_tw: %h required 321", tunning_word_o); end
  endtask

`ifdef NCO_CTRL_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    send_cmd(2'd3, 16'h0001);
    put_byte(8'h01); put_byte(8'h02); put_byte(8'hFD);
    wait_done();
    vecs++; if (err_o !== 1'b0) begin errs++; $display("FAIL cksum_good_err: %b required 0", err_o); end
    vecs++; if (wr_addr.size() != 2) begin errs++; $display("FAIL cksum_good_writes: %0d required 2", wr_addr.size()); end
    clear_log();
    send_cmd(2'd3, 16'h0001);
    put_byte(8'h01); put_byte(8'h02); put_byte(8'h00);
    wait_done();
    vecs++; if (err_o !== 1'b1) begin errs++; $display("FAIL cksum_bad_err: %b required 1", err_o); end
    vecs++; if (wr_addr.size() != 2) begin errs++; $display("FAIL cksum_bad_writes: %0d required 2", wr_addr.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_set_tw_enable();
    test_back_to_back();
    test_clamp();
    test_timeout();
`ifdef NCO_CTRL_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
